// File: rtl/joy_serial_scan.sv
// rtl/joy_serial_scan.sv - serial joystick scanner for a 74HC165 shift chain
//
// Purpose: pulses a parallel load into an external 74HC165 chain, clocks out
// NUM_PLAYERS*BITS_PER_PLAYER bits, and latches them as active-high per-player
// button words. Frames repeat after FRAME_GAP idle ticks while enable is high.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active low
//   enable       scanning enabled; dropping it aborts the current frame
//   joy_load     parallel-load strobe to the chain, active low
//   joy_clk      shift clock to the chain, data shifts on its rising edge
//   joy_data     serial data from the chain, active low (0 = pressed)
//   joystick     player p in [16p+15:16p], active high
//   frame_valid  one-clk pulse in the cycle joystick is (re)latched
//
// Optional macro JOY_SERIAL_SCAN_DEBOUNCE_EN: a frame is committed only when
// it matches the previous frame's raw data.

module joy_serial_scan #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int CLK_DIV         = 48,
    parameter int FRAME_GAP       = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    output logic                      joy_load,
    output logic                      joy_clk,
    input  logic                      joy_data,
    output logic [16*NUM_PLAYERS-1:0] joystick,
    output logic                      frame_valid
);

    localparam int N  = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int DW = $clog2(CLK_DIV);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = $clog2(FRAME_GAP + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SLOW  = 3'd2,
        SHIGH = 3'd3,
        LATCH = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t                  state;
    state_t                  nxt;
    logic [DW-1:0]           div;
    logic [KW-1:0]           k;
    logic [GW-1:0]           gap_cnt;
    logic [N-1:0]            shreg;
    logic [1:0]              sync;
    logic [16*NUM_PLAYERS-1:0] mapped;
    logic                    tick;
    logic                    last_bit;
    logic                    gap_done;

`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
    logic [N-1:0]            prev;
    logic                    prev_valid;
`endif

    assign tick     = (state != IDLE) && (div == DW'(CLK_DIV - 1));
    assign last_bit = (k == KW'(N - 1));
    assign gap_done = (gap_cnt == GW'(FRAME_GAP - 1));

    // Stream bit p*B+b lands in player p bit b, inverted to active high;
    // bits above BITS_PER_PLAYER stay 0.
    always_comb begin
        mapped = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int b = 0; b < BITS_PER_PLAYER; b++) begin
                mapped[16*p + b] = ~shreg[p*BITS_PER_PLAYER + b];
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (enable) nxt = LOAD;
            LOAD:    if (tick) nxt = SLOW;
            SLOW:    if (tick) nxt = SHIGH;
            SHIGH:   if (tick) nxt = last_bit ? LATCH : SLOW;
            LATCH:   nxt = GAP;
            GAP:     if (tick && gap_done) nxt = LOAD;
            default: nxt = IDLE;
        endcase
        if (!enable) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            div         <= '0;
            k           <= '0;
            gap_cnt     <= '0;
            shreg       <= '0;
            sync        <= 2'b11;
            joy_load    <= 1'b1;
            joy_clk     <= 1'b0;
            joystick    <= '0;
            frame_valid <= 1'b0;
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
            prev        <= '0;
            prev_valid  <= 1'b0;
`endif
        end else begin
            state <= nxt;
            sync  <= {sync[0], joy_data};

            // Strobes are registered from the next state so they are
            // glitch-free and line up exactly with the state they belong to.
            joy_load    <= (nxt != LOAD);
            joy_clk     <= (nxt == SHIGH);
            frame_valid <= (nxt == LATCH);

            // LATCH is a single clk outside the tick grid, so the divider is
            // held there and GAP starts on a fresh tick boundary.
            if (state == IDLE || nxt == IDLE || state == LATCH || tick)
                div <= '0;
            else
                div <= div + 1'b1;

            if (nxt == IDLE || state == LATCH)
                k <= '0;
            else if (state == SHIGH && tick && !last_bit)
                k <= k + 1'b1;

            if (state == SLOW && tick)
                shreg[k] <= sync[1];

            if (state != GAP)
                gap_cnt <= '0;
            else if (tick)
                gap_cnt <= gap_cnt + 1'b1;

            // The last bit was sampled on the final SLOW tick, so shreg is
            // complete on the edge that enters LATCH.
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
            if (nxt == IDLE)
                prev_valid <= 1'b0;
            if (nxt == LATCH) begin
                prev       <= shreg;
                prev_valid <= 1'b1;
                if (prev_valid && prev == shreg)
                    joystick <= mapped;
            end
`else
            if (nxt == LATCH)
                joystick <= mapped;
`endif
        end
    end

endmodule

// File: tb/tb_joy_serial_scan.sv
// tb/tb_joy_serial_scan.sv - directed self-checking bench for joy_serial_scan

module tb_joy_serial_scan;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    // main instance: 2 players x 12 bits, CLK_DIV 4, FRAME_GAP 3
    logic        en_m = 1'b0;
    logic        load_m, jclk_m, data_m, fv_m;
    logic [31:0] joy_m;
    logic [63:0] press_m = '0;
    logic [6:0]  idx_m = '0;

    // 4 players x 16 bits
    logic        en_4 = 1'b0;
    logic        load_4, jclk_4, data_4, fv_4;
    logic [63:0] joy_4;
    logic [63:0] press_4 = '0;
    logic [6:0]  idx_4 = '0;

    // 2 players x 5 bits
    logic        en_5 = 1'b0;
    logic        load_5, jclk_5, data_5, fv_5;
    logic [31:0] joy_5;
    logic [63:0] press_5 = '0;
    logic [6:0]  idx_5 = '0;

    joy_serial_scan #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .CLK_DIV(4), .FRAME_GAP(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(en_m), .joy_load(load_m), .joy_clk(jclk_m),
        .joy_data(data_m), .joystick(joy_m), .frame_valid(fv_m));

    joy_serial_scan #(.NUM_PLAYERS(4), .BITS_PER_PLAYER(16), .CLK_DIV(2), .FRAME_GAP(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(en_4), .joy_load(load_4), .joy_clk(jclk_4),
        .joy_data(data_4), .joystick(joy_4), .frame_valid(fv_4));

    joy_serial_scan #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(5), .CLK_DIV(2), .FRAME_GAP(1)) dut5 (
        .clk(clk), .reset_n(reset_n), .enable(en_5), .joy_load(load_5), .joy_clk(jclk_5),
        .joy_data(data_5), .joystick(joy_5), .frame_valid(fv_5));

    // 74HC165 chain models: load resets the stream position, each joy_clk
    // rising edge advances it; a pressed bit drives 0.
    always @(negedge load_m or posedge jclk_m) if (!load_m) idx_m <= '0; else idx_m <= idx_m + 1'b1;
    always @(negedge load_4 or posedge jclk_4) if (!load_4) idx_4 <= '0; else idx_4 <= idx_4 + 1'b1;
    always @(negedge load_5 or posedge jclk_5) if (!load_5) idx_5 <= '0; else idx_5 <= idx_5 + 1'b1;
    assign data_m = ~press_m[idx_m[5:0]];
    assign data_4 = ~press_4[idx_4[5:0]];
    assign data_5 = ~press_5[idx_5[5:0]];

    task automatic wait_fv(input int sel, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ((sel == 0 && fv_m === 1'b1) || (sel == 4 && fv_4 === 1'b1) ||
                (sel == 5 && fv_5 === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        reset_n = 1'b0;
        en_m = 1'b1;
        repeat (5) @(negedge clk);
        assertions++; if (load_m !== 1'b1) begin failures++; $display("FAIL reset_load got %b want 1", load_m); end
        assertions++; if (jclk_m !== 1'b0) begin failures++; $display("FAIL reset_clk got %b want 0", jclk_m); end
        assertions++; if (joy_m !== 32'h0) begin failures++; $display("FAIL reset_joy got %h want 0", joy_m); end
        assertions++; if (fv_m !== 1'b0) begin failures++; $display("FAIL reset_fv got %b want 0", fv_m); end
        reset_n = 1'b1;
        @(negedge clk);
        assertions++; if (load_m !== 1'b0) begin failures++; $display("FAIL load_fall got %b want 0", load_m); end
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (load_m !== 1'b0) break;
            n++;
        end
        assertions++; if (n != 4) begin failures++; $display("FAIL load_width got %0d want 4", n); end
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timing;
        int cyc, t0, t1, rises, run, bad, n;
        bit pj;
        cyc = 0; t0 = -1; t1 = -1; rises = 0; run = 0; bad = 0; pj = 1'b0;
        press_m = '0;
        en_m = 1'b1;
        while (t1 < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (load_m === 1'b0 && t0 < 0) t0 = cyc;
            if (jclk_m === 1'b1) begin
                if (!pj) rises++;
                run++;
            end else if (pj) begin
                if (run != 4) bad++;
                run = 0;
            end
            pj = jclk_m;
            if (fv_m === 1'b1) t1 = cyc;
        end
        assertions++; if (t1 < 0 || t1 - t0 != 196) begin failures++; $display("FAIL frame_len got %0d want 196", t1 - t0); end
        assertions++; if (rises != 24) begin failures++; $display("FAIL clk_rises got %0d want 24", rises); end
        assertions++; if (bad != 0) begin failures++; $display("FAIL clk_high_width got %0d bad runs want 0", bad); end
        @(negedge clk);
        assertions++; if (fv_m !== 1'b0) begin failures++; $display("FAIL fv_width got %b want 0", fv_m); end
        n = 0;
        while (load_m === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        assertions++; if (n != 12) begin failures++; $display("FAIL gap_len got %0d want 12", n); end
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mapping;
        bit ok;
        press_m = 64'h2001;
        en_m = 1'b1;
        wait_fv(0, ok);
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
        wait_fv(0, ok);
`endif
        assertions++; if (ok !== 1'b1) begin failures++; $display("FAIL map_timeout got %b want 1", ok); end
        assertions++; if (joy_m !== 32'h0002_0001) begin failures++; $display("FAIL map_joy got %h want 00020001", joy_m); end
        @(negedge clk);
        assertions++; if (fv_m !== 1'b0) begin failures++; $display("FAIL map_single_pulse got %b want 0", fv_m); end
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_generalise;
        bit ok;
        press_4 = '1;
        en_4 = 1'b1;
        wait_fv(4, ok);
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
        wait_fv(4, ok);
`endif
        assertions++; if (ok !== 1'b1) begin failures++; $display("FAIL gen16_timeout got %b want 1", ok); end
        assertions++; if (joy_4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL gen16_joy got %h want all ones", joy_4); end
        en_4 = 1'b0;
        press_5 = '1;
        en_5 = 1'b1;
        wait_fv(5, ok);
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
        wait_fv(5, ok);
`endif
        assertions++; if (ok !== 1'b1) begin failures++; $display("FAIL gen5_timeout got %b want 1", ok); end
        assertions++; if (joy_5 !== 32'h001F_001F) begin failures++; $display("FAIL gen5_joy got %h want 001f001f", joy_5); end
        en_5 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort;
        int n, fvs, t0, t1;
        bit hit;
        press_m = 64'hFFF;
        en_m = 1'b1;
        hit = 1'b0;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (idx_m == 7'd8 && jclk_m === 1'b1) begin hit = 1'b1; break; end
        end
        assertions++; if (hit !== 1'b1) begin failures++; $display("FAIL abort_reach_bit7 got %b want 1", hit); end
        en_m = 1'b0;
        @(negedge clk);
        assertions++; if (jclk_m !== 1'b0) begin failures++; $display("FAIL abort_clk got %b want 0", jclk_m); end
        assertions++; if (load_m !== 1'b1) begin failures++; $display("FAIL abort_load got %b want 1", load_m); end
        fvs = 0;
        repeat (300) begin
            @(negedge clk);
            if (fv_m === 1'b1) fvs++;
        end
        assertions++; if (fvs != 0) begin failures++; $display("FAIL abort_fv got %0d pulses want 0", fvs); end
        assertions++; if (joy_m !== 32'h0002_0001) begin failures++; $display("FAIL abort_hold got %h want 00020001", joy_m); end
        en_m = 1'b1;
        t0 = -1; t1 = -1;
        for (n = 1; n < 3000 && t1 < 0; n++) begin
            @(negedge clk);
            if (load_m === 1'b0 && t0 < 0) t0 = n;
            if (fv_m === 1'b1) t1 = n;
        end
        assertions++; if (t1 < 0 || t1 - t0 != 196) begin failures++; $display("FAIL reenable_len got %0d want 196", t1 - t0); end
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
        assertions++; if (joy_m !== 32'h0002_0001) begin failures++; $display("FAIL reenable_joy got %h want 00020001", joy_m); end
`else
        assertions++; if (joy_m !== 32'h0000_0FFF) begin failures++; $display("FAIL reenable_joy got %h want 00000fff", joy_m); end
`endif
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_debounce;
`ifdef JOY_SERIAL_SCAN_DEBOUNCE_EN
        bit ok1, ok2, ok3;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        press_m = 64'h1;
        en_m = 1'b1;
        wait_fv(0, ok1);
        assertions++; if (joy_m !== 32'h0) begin failures++; $display("FAIL deb_after_a got %h want 0", joy_m); end
        press_m = 64'h5;
        wait_fv(0, ok2);
        assertions++; if (joy_m !== 32'h0) begin failures++; $display("FAIL deb_after_b1 got %h want 0", joy_m); end
        wait_fv(0, ok3);
        assertions++; if (joy_m !== 32'h0000_0005) begin failures++; $display("FAIL deb_after_b2 got %h want 00000005", joy_m); end
        assertions++; if ({ok1, ok2, ok3} !== 3'b111) begin failures++; $display("FAIL deb_pulses got %b want 111", {ok1, ok2, ok3}); end
        en_m = 1'b0;
        repeat (3) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset;
        test_timing;
        test_mapping;
        test_generalise;
        test_abort;
        test_debounce;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/joy_serial_scan.md
Name: joy_serial_scan

Overview:
- Parametrised serial joystick scanner for the open-drain user port. Generalises the fixed two-player, 12-bit DB15 shift-register reader to N players and B bits per player, with programmable bit rate and inter-frame gap.
- Drives parallel-load and shift-clock strobes to the external 74HC165 chain and deserialises `joy_data`. Presents per-player 16-bit active-high button words to the core's joystick mux.

Parameters:
- NUM_PLAYERS, 2, number of controllers in the chain (1..4)
- BITS_PER_PLAYER, 12, bits shifted per controller (1..16); output bits above this are 0
- CLK_DIV, 48, clk cycles per tick (>=2); one tick = one half-period of `joy_clk`
- FRAME_GAP, 1000, idle ticks between end of one frame and next LOAD (>=1)

Ports:
- clk  in  1  system clock, 40-50 MHz
- reset_n  in  1  synchronous reset, active low
- enable  in  1  scanning enabled (tied to UserIO joystick mode select)
- joy_load  out  1  parallel-load strobe to shift chain, active low
- joy_clk  out  1  shift clock to chain, data shifts on rising edge
- joy_data  in  1  serial data from chain, active low (0 = pressed)
- joystick  out  16*NUM_PLAYERS  player p in [16p+15:16p], active high, bit order R,L,D,U,then buttons
- frame_valid  out  1  one-clk pulse when `joystick` is (re)latched

Behaviour:
- Reset: checked on every rising clk; reset_n=0 takes priority over everything.
  - Outputs on reset: `joy_load`=1, `joy_clk`=0, `joystick`=0, `frame_valid`=0.
  - Tick divider=0, bit counter=0, state=IDLE.
- Tick: divider counts 0..CLK_DIV-1 and only while state != IDLE. `tick` is asserted in the cycle the divider equals CLK_DIV-1.
- Frame length: N = NUM_PLAYERS*BITS_PER_PLAYER bits.
- States:
  - IDLE: `joy_load`=1, `joy_clk`=0. If enable=1, go to LOAD on the next clk.
  - LOAD: `joy_load`=0 for exactly 1 tick. On tick: `joy_load`<=1, go to SLOW.
  - SLOW: `joy_clk`=0 for 1 tick. On tick: sample `joy_data` into shift reg position k, where k is the current bit index; go to SHIGH.
  - SHIGH: `joy_clk`=1 for 1 tick. On tick: `joy_clk`<=0. If k==N-1, go to LATCH; else k<=k+1 and go to SLOW.
  - LATCH: single clk. `joystick` <= inverted shift data mapped as below; `frame_valid`=1 this cycle only; k<=0; go to GAP.
  - GAP: count FRAME_GAP ticks with `joy_clk`=0 and `joy_load`=1, then go to LOAD.
- Bit mapping: stream bit k goes to player k/BITS_PER_PLAYER, bit k%BITS_PER_PLAYER. The first sampled bit is player 0 bit 0.
- Timing: from leaving IDLE to the LATCH cycle is exactly CLK_DIV*(1+2N) clks. With defaults, 48*49 = 2352 clks.
- enable deasserted:
  - Mid-frame (LOAD/SLOW/SHIGH/GAP): next clk returns to IDLE; `joy_clk`<=0, `joy_load`<=1, divider and k cleared.
  - `joystick` holds its last latched value. No `frame_valid` is produced for an aborted frame.
- Re-enable always starts a full frame from LOAD; partial data is discarded.
- `joy_data` is double-flop synchronised before sampling. The 2-clk latency is covered because CLK_DIV>=2 and sampling occurs at the end of the low phase.
- `joystick` changes only in the LATCH cycle (or on reset); it is glitch-free between latches.

Optional Feature:
- Macro: JOY_SERIAL_SCAN_DEBOUNCE_EN.
- Defined:
  - A frame's data is committed to `joystick` only if it equals the previous frame's raw data, held in a second N-bit register cleared on reset.
  - `frame_valid` pulses every LATCH regardless.
  - The first frame after reset or re-enable never commits, because the compare register is invalidated.
- Undefined: every LATCH commits directly; no compare register is synthesised.

Test Plan:
- Reset/idle: hold reset_n=0 for 5 clks with enable=1 -> `joy_load`=1, `joy_clk`=0, `joystick`=0, `frame_valid`=0. Release -> `joy_load` falls after 1 clk and stays low for CLK_DIV clks.
- Timing, defaults with CLK_DIV=4: enable rising to `frame_valid` takes 196 clks. Exactly 24 `joy_clk` rising edges, each high 4 clks. Next `joy_load` fall comes FRAME_GAP*4 clks after LATCH.
- Mapping: model drives `joy_data`=0 only on stream bits 0 and 13 -> `joystick`=32'h0002_0001 with a single `frame_valid` pulse.
- Generalisation: NUM_PLAYERS=4, BITS_PER_PLAYER=16, all bits pressed -> `joystick`=64'hFFFF_FFFF_FFFF_FFFF. With BITS_PER_PLAYER=5 and all pressed -> each word is 16'h001F.
- Abort: drop enable during SHIGH of bit 7 -> `joy_clk`=0 next clk, no `frame_valid`, `joystick` unchanged. Re-enable -> full 196-clk frame.
- Debounce (macro defined): frames A,B,B -> `joystick` stays 0 after A and after the first B, becomes B after the second B. Three `frame_valid` pulses total.
